data_sram_like_slave: RTL and testbench

Data-side memory responder for the pipeline's sram-like data port. It accepts load and store requests from the EXE stage with an addr_ok handshake, holds them in an in-order outstanding queue, and returns data_ok/rdata to the MEM stage after a fixed latency. It backs a word-organised RAM with byte write strobes. It serves as the data memory in simulation and as the reference model for MEM-stage load-wait logic.

---
 rtl/data_sram_like_slave.sv | 110 +++++++++++
 tb/tb_data_sram_like_slave.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_like_slave.sv
// Sram-like data-port responder: word RAM with byte strobes, in-order
// outstanding queue, and a fixed acceptance-to-data_ok latency.
module data_sram_like_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int OUTSTANDING = 2,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int DEPTH = 1 << PW;
    localparam int CW    = $clog2(OUTSTANDING + 1);
    localparam int TW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CW-1:0] FULL_CNT   = CW'(OUTSTANDING);
    localparam logic [TW-1:0] TIMER_INIT = TW'(LATENCY - 1);
    localparam logic [PW-1:0] LAST_PTR   = PW'(OUTSTANDING - 1);

    logic [31:0]           r_mem [2**ADDR_WIDTH];

    // Queue slots are padded to a power of two; only OUTSTANDING are used.
    logic [DEPTH-1:0]      r_vld;
    logic                  r_wr    [DEPTH];
    logic [31:0]           r_rdata [DEPTH];
    logic [TW-1:0]         r_timer [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_head_ready;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_idx    = data_sram_addr[ADDR_WIDTH+1:2];
    assign w_unused = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2],
                        data_sram_addr[1:0]};

    // A pop in the same cycle does not free a slot for acceptance.
    assign data_sram_addr_ok = !reset && (r_count < FULL_CNT);
    assign w_accept          = data_sram_req && data_sram_addr_ok;

    assign w_head_ready      = r_vld[r_head] && (r_timer[r_head] == '0);
    assign data_sram_data_ok = !reset && w_head_ready;
    assign w_pop             = data_sram_data_ok;
    assign data_sram_rdata   = (data_sram_data_ok && !r_wr[r_head]) ?
                               r_rdata[r_head] : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_vld   <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= ptr_inc(r_head);
            end
            if (w_accept) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= ptr_inc(r_tail);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload and timers; a push overrides the countdown of its slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (r_timer[i] != '0)
                r_timer[i] <= r_timer[i] - 1'b1;
        end
        if (w_accept) begin
            r_timer[r_tail] <= TIMER_INIT;
            r_wr[r_tail]    <= data_sram_wr;
            r_rdata[r_tail] <= data_sram_wr ? 32'h0 : r_mem[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b])
                    r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Directed bench: per-cycle vector table on a LATENCY=2/OUTSTANDING=2 instance,
// plus hand sequences for reset mid-flight and a LATENCY=3/OUTSTANDING=1 throttle.
module tb_data_sram_like_slave;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_req, a_wr;
    logic [1:0]  a_size;
    logic [3:0]  a_wstrb;
    logic [31:0] a_addr, a_wdata;
    logic        a_aok, a_dok;
    logic [31:0] a_rdata;

    logic        b_req, b_wr;
    logic [1:0]  b_size;
    logic [3:0]  b_wstrb;
    logic [31:0] b_addr, b_wdata;
    logic        b_aok, b_dok;
    logic [31:0] b_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_sram_like_slave #(.ADDR_WIDTH(12), .OUTSTANDING(2), .LATENCY(2)) u_a (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (a_req),
        .data_sram_wr      (a_wr),
        .data_sram_size    (a_size),
        .data_sram_wstrb   (a_wstrb),
        .data_sram_addr    (a_addr),
        .data_sram_wdata   (a_wdata),
        .data_sram_addr_ok (a_aok),
        .data_sram_data_ok (a_dok),
        .data_sram_rdata   (a_rdata)
    );

    data_sram_like_slave #(.ADDR_WIDTH(12), .OUTSTANDING(1), .LATENCY(3)) u_b (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (b_req),
        .data_sram_wr      (b_wr),
        .data_sram_size    (b_size),
        .data_sram_wstrb   (b_wstrb),
        .data_sram_addr    (b_addr),
        .data_sram_wdata   (b_wdata),
        .data_sram_addr_ok (b_aok),
        .data_sram_data_ok (b_dok),
        .data_sram_rdata   (b_rdata)
    );

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic req, input logic wr, input logic [3:0] wstrb,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic aok, input logic dok, input logic [31:0] rdata);
        vec_t v;
        v.req = req; v.wr = wr; v.wstrb = wstrb; v.addr = addr; v.wdata = wdata;
        v.aok = aok; v.dok = dok; v.rdata = rdata;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic req, input logic wr, input logic [3:0] wstrb,
                           input logic [31:0] addr, input logic [31:0] wdata);
        a_req = req; a_wr = wr; a_wstrb = wstrb; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic wr, input logic [3:0] wstrb,
                           input logic [31:0] addr, input logic [31:0] wdata);
        b_req = req; b_wr = wr; b_wstrb = wstrb; b_addr = addr; b_wdata = wdata;
    endtask

    task automatic chk_a(input string tag, input logic aok, input logic dok,
                         input logic [31:0] rd);
        chk({tag, ".addr_ok"}, {31'h0, a_aok}, {31'h0, aok});
        chk({tag, ".data_ok"}, {31'h0, a_dok}, {31'h0, dok});
        chk({tag, ".rdata"}, a_rdata, rd);
    endtask

    task automatic chk_b(input string tag, input logic aok, input logic dok,
                         input logic [31:0] rd);
        chk({tag, ".addr_ok"}, {31'h0, b_aok}, {31'h0, aok});
        chk({tag, ".data_ok"}, {31'h0, b_dok}, {31'h0, dok});
        chk({tag, ".rdata"}, b_rdata, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_size = 2'd2;
        b_size = 2'd2;
        reset  = 1'b1;
        drive_a(1'b1, 1'b1, 4'hF, 32'h100, 32'hFFFF_FFFF);
        drive_b(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);

        // While reset is high nothing is accepted and outputs are quiet.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_a("rst_a", 1'b0, 1'b0, 32'h0);
        chk_b("rst_b", 1'b0, 1'b0, 32'h0);

        // Rows are consecutive cycles. addr_ok ignores a same-cycle pop, so
        // a full queue blocks acceptance even while its head is answering.
        add(1, 1, 4'hF, 32'h0000_0100, 32'h1234_5678, 1, 0, 32'h0);           // k0 store
        add(1, 0, 4'h0, 32'h0000_0100, 32'h0,          1, 0, 32'h0);           // k1 load
        add(1, 0, 4'h0, 32'h0000_0200, 32'h0,          0, 1, 32'h0);           // k2 full, store resp
        add(1, 1, 4'h2, 32'h0000_0101, 32'h0000_AB00,  1, 1, 32'h1234_5678);   // k3 push+pop
        add(1, 0, 4'h0, 32'h0000_0103, 32'h0,          1, 0, 32'h0);           // k4
        add(0, 0, 4'h0, 32'h0,         32'h0,          0, 1, 32'h0);           // k5
        add(1, 1, 4'hF, 32'h0000_4010, 32'hCAFE_F00D,  1, 1, 32'h1234_AB78);   // k6 alias store
        add(1, 0, 4'h0, 32'h0000_0010, 32'h0,          1, 0, 32'h0);           // k7
        add(0, 0, 4'h0, 32'h0,         32'h0,          0, 1, 32'h0);           // k8
        add(0, 0, 4'h0, 32'h0,         32'h0,          1, 1, 32'hCAFE_F00D);   // k9
        add(1, 0, 4'h0, 32'h0000_0100, 32'h0,          1, 0, 32'h0);           // k10 L1
        add(1, 0, 4'h0, 32'h0000_0010, 32'h0,          1, 0, 32'h0);           // k11 L2
        add(1, 0, 4'h0, 32'h0000_0100, 32'h0,          0, 1, 32'h1234_AB78);   // k12 held
        add(1, 0, 4'h0, 32'h0000_0100, 32'h0,          1, 1, 32'hCAFE_F00D);   // k13 L3
        add(1, 0, 4'h0, 32'h0000_0010, 32'h0,          1, 0, 32'h0);           // k14 L4
        add(0, 0, 4'h0, 32'h0,         32'h0,          0, 1, 32'h1234_AB78);   // k15
        add(0, 0, 4'h0, 32'h0,         32'h0,          1, 1, 32'hCAFE_F00D);   // k16
        add(1, 1, 4'h0, 32'h0000_0100, 32'hFFFF_FFFF,  1, 0, 32'h0);           // k17 wstrb=0
        add(1, 0, 4'h0, 32'h0000_0100, 32'h0,          1, 0, 32'h0);           // k18
        add(0, 0, 4'h0, 32'h0,         32'h0,          0, 1, 32'h0);           // k19
        add(0, 0, 4'h0, 32'h0,         32'h0,          1, 1, 32'h1234_AB78);   // k20
        add(0, 0, 4'h0, 32'h0,         32'h0,          1, 0, 32'h0);           // k21

        @(negedge clk);
        reset = 1'b0;
        drive_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < tbl.size(); k++) begin
            if (k > 0) @(negedge clk);
            drive_a(tbl[k].req, tbl[k].wr, tbl[k].wstrb, tbl[k].addr, tbl[k].wdata);
            #1;
            chk_a($sformatf("vec%0d", k), tbl[k].aok, tbl[k].dok, tbl[k].rdata);
        end

        // Reset mid-flight: the load's response is dropped, the store
        // presented during reset is not accepted.
        @(negedge clk);
        drive_a(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        #1; chk_a("rmf_c0", 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive_a(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        #1; chk_a("rmf_c1", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1; chk_a("rmf_c2", 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive_a(1'b1, 1'b0, 4'h0, 32'h102, 32'h0);
        #1; chk_a("rmf_c3", 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1; chk_a("rmf_c4", 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1; chk_a("rmf_c5", 1'b1, 1'b1, 32'h1234_AB78);
        @(negedge clk);
        #1; chk_a("rmf_c6", 1'b1, 1'b0, 32'h0);

        // Full throttle on the single-entry, latency-3 instance.
        @(negedge clk);
        drive_b(1'b1, 1'b1, 4'hF, 32'h20, 32'h5A5A_5A5A);
        #1; chk_b("thr_c0", 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive_b(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        #1; chk_b("thr_c1", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1; chk_b("thr_c2", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1; chk_b("thr_c3", 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        #1; chk_b("thr_c4", 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive_b(1'b1, 1'b1, 4'hF, 32'h20, 32'h0);
        #1; chk_b("thr_c5", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1; chk_b("thr_c6", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1; chk_b("thr_c7", 1'b0, 1'b1, 32'h5A5A_5A5A);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1; chk_b("thr_c8", 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1; chk_b("thr_c9", 1'b1, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
